// File: rtl/rcv_capture_module_pkg.sv
// Shared command encodings (also used by the transducer output block) and capture FSM states.
// Constants only: no latency, no flow control.
package rcv_capture_module_pkg;

    localparam logic [1:0] CMD_WAIT      = 2'b00;
    localparam logic [1:0] CMD_ARM       = 2'b01;
    localparam logic [1:0] CMD_RESET     = 2'b10;
    localparam logic [1:0] CMD_RESET_ALT = 2'b11;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    localparam int DECIM_W = 4;
    localparam int DELAY_W = 16;

endpackage

// File: rtl/rcv_decimator.sv
// Keep-one-in-(reload+1) counter: tick is high while the count is zero, so the next enabled sample is kept.
// Tick is combinational from the count register; no backpressure.
module rcv_decimator
    import rcv_capture_module_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               en,
    input  logic [DECIM_W-1:0] reload,
    output logic               tick
);

    logic [DECIM_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == '0) ? reload : cnt - DECIM_W'(1);
        end
    end

    assign tick = (cnt == '0);

endmodule

// File: rtl/rcv_capture_module.sv
// Receive capture: waits for cntr to reach the latched delay, then writes decimated ADC samples to an external buffer.
// Write strobe lags the accepted sample by one cycle; the ADC is never stalled and a dead ADC trips the watchdog.
module rcv_capture_module
    import rcv_capture_module_pkg::*;
#(
    parameter int ADC_W  = 12,
    parameter int ADDR_W = 14,
    parameter int WDOG_W = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        cntr,
    input  logic [1:0]         cmd,
    input  logic [DELAY_W-1:0] recDelay,
    input  logic [ADDR_W-1:0]  recLength,
    input  logic [DECIM_W-1:0] decim,
    input  logic [ADC_W-1:0]   adcData,
    input  logic               adcValid,
    output logic               wrEn,
    output logic [ADDR_W-1:0]  wrAddr,
    output logic [ADC_W-1:0]   wrData,
    output logic               isActive,
    output logic               done,
    output logic               errorFlag
);

    localparam logic [WDOG_W-1:0] WDOG_LAST = {{(WDOG_W-1){1'b1}}, 1'b0};

    logic [1:0]         st;
    logic               cmdArmQ;
    logic [DELAY_W-1:0] delayQ;
    logic [ADDR_W-1:0]  lenQ;
    logic [DECIM_W-1:0] decimQ;
    logic [ADDR_W-1:0]  idx;
    logic [WDOG_W-1:0]  wdCnt;

    logic armCmd, clrCmd, armEdge, openNow, decEn, decTick, capture, wdTrip;

    always_comb begin
        armCmd = 1'b0;
        clrCmd = 1'b0;
        unique case (cmd)
            CMD_WAIT:                 ;
            CMD_ARM:                  armCmd = 1'b1;
            CMD_RESET, CMD_RESET_ALT: clrCmd = 1'b1;
            default:                  ;
        endcase
    end

    // Only a fresh 01 arms, so a held command cannot start a second capture.
    assign armEdge = armCmd && !cmdArmQ;
    assign openNow = (st == ST_ARMED) && (cntr >= {16'h0, delayQ});
    assign decEn   = (st == ST_CAPTURE) && armCmd && adcValid;
    assign capture = decEn && decTick && (idx != lenQ);
    assign wdTrip  = (st == ST_CAPTURE) && armCmd && !adcValid && (wdCnt == WDOG_LAST);

    rcv_decimator u_decim (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (openNow),
        .en     (decEn),
        .reload (decimQ),
        .tick   (decTick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= ST_IDLE;
            cmdArmQ   <= 1'b0;
            delayQ    <= '0;
            lenQ      <= '0;
            decimQ    <= '0;
            idx       <= '0;
            wdCnt     <= '0;
            wrEn      <= 1'b0;
            wrAddr    <= '0;
            wrData    <= '0;
            errorFlag <= 1'b0;
        end else begin
            cmdArmQ <= armCmd;
            wrEn    <= capture;
            if (capture) begin
                wrAddr <= idx;
                wrData <= adcData;
                idx    <= idx + ADDR_W'(1);
            end

            if ((st == ST_CAPTURE) && !adcValid) begin
                wdCnt <= wdCnt + WDOG_W'(1);
            end else begin
                wdCnt <= '0;
            end

            if (clrCmd) begin
                errorFlag <= 1'b0;
            end else if (wdTrip) begin
                errorFlag <= 1'b1;
            end

            unique case (st)
                ST_IDLE: begin
                    if (armEdge) begin
                        delayQ <= recDelay;
                        lenQ   <= recLength;
                        decimQ <= decim;
                        idx    <= '0;
                        st     <= (recLength == '0) ? ST_DONE : ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (!armCmd) begin
                        st <= ST_IDLE;
                    end else if (openNow) begin
                        st <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    // idx reaches lenQ on the edge that raises the last wrEn; DONE follows one cycle later.
                    if (!armCmd || wdTrip) begin
                        st <= ST_IDLE;
                    end else if (idx == lenQ) begin
                        st <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!armCmd) begin
                        st <= ST_IDLE;
                    end
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

    assign isActive = (st == ST_ARMED) || (st == ST_CAPTURE);
    assign done     = (st == ST_DONE);

endmodule

// File: tb/tb_rcv_capture_module.sv
// Randomized bench for rcv_capture_module: per-edge stimulus/response log checked against a sample-list model.
module tb_rcv_capture_module;
    import rcv_capture_module_pkg::*;

    localparam int ADC_W  = 12;
    localparam int ADDR_W = 14;
    localparam int WDOG_W = 10;
    localparam int MAXE   = 4096;

    logic              clk;
    logic              rst_n;
    logic [31:0]       cntr;
    logic [1:0]        cmd;
    logic [15:0]       recDelay;
    logic [ADDR_W-1:0] recLength;
    logic [3:0]        decim;
    logic [ADC_W-1:0]  adcData;
    logic              adcValid;
    logic              wrEn;
    logic [ADDR_W-1:0] wrAddr;
    logic [ADC_W-1:0]  wrData;
    logic              isActive;
    logic              done;
    logic              errorFlag;

    int errors = 0;
    int checks = 0;

    // inX[e]: inputs sampled at edge e; outX[e]: outputs seen just after edge e
    logic [31:0]       inCntr [MAXE];
    logic              inValid[MAXE];
    logic [ADC_W-1:0]  inData [MAXE];
    logic              outWrEn[MAXE];
    logic [ADDR_W-1:0] outAddr[MAXE];
    logic [ADC_W-1:0]  outData[MAXE];
    logic              outActive[MAXE];
    logic              outDone[MAXE];
    logic              outErr[MAXE];
    int ne;
    int validPct;
    bit scramble;

    int expEdge[$];
    int expAddr[$];
    logic [ADC_W-1:0] expData[$];
    int obsEdge[$];
    int obsAddr[$];
    logic [ADC_W-1:0] obsData[$];

    rcv_capture_module #(.ADC_W(ADC_W), .ADDR_W(ADDR_W), .WDOG_W(WDOG_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cntr      (cntr),
        .cmd       (cmd),
        .recDelay  (recDelay),
        .recLength (recLength),
        .decim     (decim),
        .adcData   (adcData),
        .adcValid  (adcValid),
        .wrEn      (wrEn),
        .wrAddr    (wrAddr),
        .wrData    (wrData),
        .isActive  (isActive),
        .done      (done),
        .errorFlag (errorFlag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        if (ne < MAXE) begin
            inCntr[ne]  = cntr;
            inValid[ne] = adcValid;
            inData[ne]  = adcData;
        end
        @(posedge clk);
        #1;
        if (ne < MAXE) begin
            outWrEn[ne]   = wrEn;
            outAddr[ne]   = wrAddr;
            outData[ne]   = wrData;
            outActive[ne] = isActive;
            outDone[ne]   = done;
            outErr[ne]    = errorFlag;
        end
        ne++;
        cntr = cntr + 32'd1;
        if (scramble) begin
            recDelay  = 16'($urandom);
            recLength = ADDR_W'($urandom);
            decim     = 4'($urandom);
        end
        adcValid = ($urandom_range(99) < validPct);
        adcData  = ADC_W'($urandom);
    endtask

    // Leaves the bench just after the arming edge, which is logged as edge 0.
    task automatic run_arm(input int d, input int len, input int dec, input int startCntr);
        scramble = 0;
        cmd = CMD_WAIT;
        tick();
        tick();
        ne = 0;
        cntr = 32'(startCntr);
        recDelay = 16'(d);
        recLength = ADDR_W'(len);
        decim = 4'(dec);
        cmd = CMD_ARM;
        tick();
        scramble = 1;
    endtask

    task automatic wait_done(input int budget, input int extra);
        int n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        repeat (extra) tick();
    endtask

    task automatic collect_obs();
        obsEdge.delete(); obsAddr.delete(); obsData.delete();
        for (int e = 0; e < ne && e < MAXE; e++) begin
            if (outWrEn[e]) begin
                obsEdge.push_back(e);
                obsAddr.push_back(int'(outAddr[e]));
                obsData.push_back(outData[e]);
            end
        end
    endtask

    // Capture opens at the first edge after arming with cntr >= delay; every
    // (dec+1)-th valid sample after that is stored, each visible one edge later.
    task automatic model(input int a, input int d, input int len, input int dec, output int doneE);
        int o = -1;
        int k = 0;
        int kept = 0;
        int last = -1;
        expEdge.delete(); expAddr.delete(); expData.delete();
        for (int e = a + 1; e < ne && o < 0; e++)
            if (inCntr[e] >= 32'(d)) o = e;
        if (o >= 0) begin
            for (int e = o + 1; e < ne && kept < len; e++) begin
                if (inValid[e]) begin
                    if (k % (dec + 1) == 0) begin
                        expEdge.push_back(e);
                        expAddr.push_back(kept);
                        expData.push_back(inData[e]);
                        kept++;
                        last = e;
                    end
                    k++;
                end
            end
        end
        doneE = (len == 0) ? a : ((kept == len) ? last + 1 : -1);
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({wrEn, wrAddr, wrData, isActive, done, errorFlag} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got wrEn=%b addr=%0d data=%h act=%b done=%b err=%b, want all 0",
                     wrEn, wrAddr, wrData, isActive, done, errorFlag);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (isActive !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got act=%b done=%b, want 0 0", isActive, done);
        end
    endtask

    task automatic test_basic();
        int dE;
        validPct = 100;
        run_arm(100, 8, 0, 50);
        wait_done(300, 4);
        model(0, 100, 8, 0, dE);
        collect_obs();
        checks++;
        if (obsEdge.size() != 8 || expEdge.size() != 8) begin
            errors++;
            $display("FAIL basic_count got %0d writes, want 8 (model %0d)", obsEdge.size(), expEdge.size());
        end
        for (int i = 0; i < expEdge.size() && i < obsEdge.size(); i++) begin
            checks++;
            if (obsEdge[i] != expEdge[i] || obsAddr[i] != expAddr[i] || obsData[i] !== expData[i]) begin
                errors++;
                $display("FAIL basic_wr[%0d] got edge=%0d addr=%0d data=%h, want edge=%0d addr=%0d data=%h",
                         i, obsEdge[i], obsAddr[i], obsData[i], expEdge[i], expAddr[i], expData[i]);
            end
        end
        if (obsEdge.size() == 8) begin
            checks++;
            if (inCntr[obsEdge[0]] + 32'd1 != 32'd102 || obsEdge[7] - obsEdge[0] != 7) begin
                errors++;
                $display("FAIL basic_timing got first cntr=%0d span=%0d, want 102 7",
                         inCntr[obsEdge[0]] + 32'd1, obsEdge[7] - obsEdge[0]);
            end
        end
        checks++;
        if (outActive[0] !== 1'b1) begin
            errors++;
            $display("FAIL basic_armed_active got %b, want 1", outActive[0]);
        end
        checks++;
        if (dE < 1 || dE >= ne) begin
            errors++;
            $display("FAIL basic_done_edge got none, want edge after last write");
        end else if (outDone[dE] !== 1'b1 || outDone[dE-1] !== 1'b0 || outActive[dE] !== 1'b0) begin
            errors++;
            $display("FAIL basic_done got done=%b prev=%b act=%b, want 1 0 0",
                     outDone[dE], outDone[dE-1], outActive[dE]);
        end
    endtask

    task automatic test_decim();
        int dE;
        validPct = 100;
        run_arm(5, 4, 3, 0);
        wait_done(200, 4);
        model(0, 5, 4, 3, dE);
        collect_obs();
        checks++;
        if (obsEdge.size() != 4) begin
            errors++;
            $display("FAIL decim_count got %0d writes, want 4", obsEdge.size());
        end
        for (int i = 0; i < expEdge.size() && i < obsEdge.size(); i++) begin
            checks++;
            if (obsEdge[i] != expEdge[i] || obsAddr[i] != i || obsData[i] !== expData[i]) begin
                errors++;
                $display("FAIL decim_wr[%0d] got edge=%0d addr=%0d data=%h, want edge=%0d addr=%0d data=%h",
                         i, obsEdge[i], obsAddr[i], obsData[i], expEdge[i], i, expData[i]);
            end
        end
        if (obsEdge.size() == 4) begin
            checks++;
            if (obsEdge[3] - obsEdge[0] != 12) begin
                errors++;
                $display("FAIL decim_spacing got %0d, want 12", obsEdge[3] - obsEdge[0]);
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            int d, len, dec, sc, dE;
            d = $urandom_range(40);
            len = $urandom_range(12, 1);
            dec = $urandom_range(5);
            sc = $urandom_range(60);
            validPct = $urandom_range(100, 60);
            run_arm(d, len, dec, sc);
            wait_done(200 + len * (dec + 1) * 4, 3);
            model(0, d, len, dec, dE);
            collect_obs();
            checks++;
            if (obsEdge.size() != expEdge.size() || expEdge.size() != len) begin
                errors++;
                $display("FAIL rand%0d_count got %0d writes, want %0d", it, obsEdge.size(), len);
            end
            for (int i = 0; i < expEdge.size() && i < obsEdge.size(); i++) begin
                checks++;
                if (obsEdge[i] != expEdge[i] || obsAddr[i] != expAddr[i] || obsData[i] !== expData[i]) begin
                    errors++;
                    $display("FAIL rand%0d_wr[%0d] got edge=%0d addr=%0d data=%h, want edge=%0d addr=%0d data=%h",
                             it, i, obsEdge[i], obsAddr[i], obsData[i], expEdge[i], expAddr[i], expData[i]);
                end
            end
            checks++;
            if (dE < 1 || dE >= ne || outDone[dE] !== 1'b1 || outDone[dE-1] !== 1'b0) begin
                errors++;
                $display("FAIL rand%0d_done got done edge mismatch at model edge %0d, want rise there", it, dE);
            end
        end
    endtask

    task automatic test_zero_len();
        bit sawActive = 0;
        validPct = 100;
        run_arm(7, 0, 2, 0);
        repeat (10) tick();
        collect_obs();
        for (int e = 0; e < ne; e++) if (outActive[e]) sawActive = 1;
        checks++;
        if (outDone[0] !== 1'b1) begin
            errors++;
            $display("FAIL zero_len_done got %b, want 1", outDone[0]);
        end
        checks++;
        if (obsEdge.size() != 0 || sawActive) begin
            errors++;
            $display("FAIL zero_len_quiet got writes=%0d active=%b, want 0 0", obsEdge.size(), sawActive);
        end
    endtask

    task automatic test_watchdog();
        int o = -1;
        validPct = 0;
        run_arm(0, 8, 0, 0);
        repeat (1030) tick();
        for (int e = 1; e < ne && o < 0; e++) if (inCntr[e] >= 32'd0) o = e;
        collect_obs();
        checks++;
        if (outErr[o + 1022] !== 1'b0 || outErr[o + 1023] !== 1'b1) begin
            errors++;
            $display("FAIL wdog_edge got err=%b then %b, want 0 then 1", outErr[o + 1022], outErr[o + 1023]);
        end
        checks++;
        if (outActive[o + 1023] !== 1'b0 || outActive[ne - 1] !== 1'b0 || obsEdge.size() != 0) begin
            errors++;
            $display("FAIL wdog_idle got act=%b late_act=%b writes=%0d, want 0 0 0",
                     outActive[o + 1023], outActive[ne - 1], obsEdge.size());
        end
        cmd = CMD_WAIT;
        tick();
        checks++;
        if (errorFlag !== 1'b1) begin
            errors++;
            $display("FAIL wdog_retain got %b, want 1", errorFlag);
        end
        cmd = CMD_RESET;
        tick();
        checks++;
        if (errorFlag !== 1'b0) begin
            errors++;
            $display("FAIL wdog_clear got %b, want 0", errorFlag);
        end
    endtask

    task automatic test_abort();
        int n = 0;
        logic [ADDR_W-1:0] preAddr;
        logic preEn;
        validPct = 100;
        run_arm(3, 8, 0, 0);
        collect_obs();
        while (obsEdge.size() < 3 && n < 100) begin
            tick();
            collect_obs();
            n++;
        end
        cmd = CMD_WAIT;
        repeat (20) tick();
        collect_obs();
        checks++;
        if (obsEdge.size() != 3) begin
            errors++;
            $display("FAIL abort_writes got %0d, want 3", obsEdge.size());
        end
        checks++;
        if (isActive !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle got act=%b done=%b, want 0 0", isActive, done);
        end

        run_arm(3, 8, 0, 0);
        n = 0;
        while (!wrEn && n < 100) begin
            tick();
            n++;
        end
        tick();
        preEn = wrEn;
        preAddr = wrAddr;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (preEn !== 1'b1 || preAddr !== ADDR_W'(1)) begin
            errors++;
            $display("FAIL rst_setup got wrEn=%b addr=%0d, want 1 1", preEn, preAddr);
        end
        checks++;
        if ({wrEn, wrAddr, wrData, isActive, done, errorFlag} !== '0) begin
            errors++;
            $display("FAIL rst_async got wrEn=%b addr=%0d data=%h act=%b done=%b err=%b, want all 0",
                     wrEn, wrAddr, wrData, isActive, done, errorFlag);
        end
        cmd = CMD_WAIT;
        #3;
        rst_n = 1'b1;
    endtask

    task automatic test_held_arm();
        int dE;
        validPct = 100;
        run_arm(10, 3, 0, 500);
        wait_done(100, 30);
        model(0, 10, 3, 0, dE);
        collect_obs();
        checks++;
        if (obsEdge.size() != 3 || expEdge.size() != 3) begin
            errors++;
            $display("FAIL held_count got %0d writes, want 3", obsEdge.size());
        end
        if (obsEdge.size() > 0) begin
            checks++;
            if (obsEdge[0] != 2 || obsEdge[0] != expEdge[0]) begin
                errors++;
                $display("FAIL early_arm_first got edge %0d, want 2", obsEdge[0]);
            end
        end
        checks++;
        if (done !== 1'b1 || isActive !== 1'b0) begin
            errors++;
            $display("FAIL held_done got done=%b act=%b, want 1 0", done, isActive);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        cntr = '0;
        cmd = CMD_WAIT;
        recDelay = '0;
        recLength = '0;
        decim = '0;
        adcData = '0;
        adcValid = 1'b0;
        ne = 0;
        validPct = 0;
        scramble = 0;
        test_reset();
        test_basic();
        test_decim();
        test_random();
        test_zero_len();
        test_watchdog();
        test_abort();
        test_held_arm();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
